vga_sprite_display: RTL and testbench
=====================================

Name: vga_sprite_display

Overview:
- Parametrised successor to the single-picture VGA display stage. Generates its own 640x480@60 timing and a background-picture RAM read with aligned latency.
- Composites N_OBJ solid-colour rectangular sprites over the picture. Sprite index 0 has the highest priority.
- Latches sprite and picture positions once per frame, so a frame never tears.
- Reports per-sprite pixel-overlap collisions once per frame to the game logic.

Parameters:
- N_OBJ, 4, number of sprites.
- OBJ_W, 40, sprite width in pixels.
- OBJ_H, 40, sprite height in pixels.
- PIC_W, 640, background picture width in pixels.
- PIC_H, 480, background picture height in pixels.
- ADDR_W, 19, picture RAM address width.
- H_VIS / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal timing; H_TOTAL = sum = 800.
- V_VIS / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing; V_TOTAL = sum = 525.
- BG_COLOR, 12'hFCD, RGB444 colour outside the picture window.

Ports:
- clk_vga, in, 1, pixel clock, 25.175 MHz.
- rst, in, 1, asynchronous, active-low reset.
- pic_x_begin, in, 11, picture window left edge in visible coordinates.
- pic_y_begin, in, 11, picture window top edge.
- obj_x, in, 11*N_OBJ, packed sprite left edges; object i uses bits [11i+10:11i].
- obj_y, in, 11*N_OBJ, packed sprite top edges.
- obj_show, in, N_OBJ, per-sprite enable.
- obj_color, in, 12*N_OBJ, packed RGB444 colour per sprite.
- color_data_in, in, 16, RGB565 data from picture RAM, valid 1 cycle after ram_en.
- ram_addr, out, ADDR_W, picture RAM read address.
- ram_en, out, 1, picture RAM read enable.
- hsync, out, 1, horizontal sync, active low.
- vsync, out, 1, vertical sync, active low.
- red, out, 4, pixel red.
- green, out, 4, pixel green.
- blue, out, 4, pixel blue.
- frame_tick, out, 1, one-cycle pulse at the end of each frame.
- collide, out, N_OBJ, per-sprite collision flags for the last completed frame.

Behaviour:
- Reset (rst=0, async): h_cnt=0, v_cnt=0; all pipeline regs 0; ram_en=0; ram_addr=0; RGB=0; hsync=1; vsync=1; frame_tick=0; collide=0; all shadow regs 0, so no sprite is shown until the first latch.
- Counters: h_cnt increments every clock and wraps H_TOTAL-1 -> 0. v_cnt increments on h wrap and wraps V_TOTAL-1 -> 0.
- Frame end is the cycle with h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. On that cycle:
  - shadow regs load pic_x_begin, pic_y_begin, obj_x, obj_y, obj_show, obj_color;
  - collide loads the collision accumulator;
  - the accumulator clears;
  - frame_tick=1 on the following cycle only.
  - Input changes at any other time have no visible effect until the next frame.
- Stage 0 (counter cycle), computed from the shadow regs:
  - vis = h<H_VIS and v<V_VIS.
  - pic_in = vis, h>=px, h<px+PIC_W, v>=py, v<py+PIC_H. Compare at 12 bits so px+PIC_W cannot overflow.
  - hit[i] = show[i], h in [x_i, x_i+OBJ_W), v in [y_i, y_i+OBJ_H), vis.
- Stage 1 (registered):
  - ram_en = pic_in.
  - ram_addr = (v-py)*PIC_W + (h-px), truncated to ADDR_W; holds its previous value when pic_in=0.
  - The vis, pic_in, hit vector, selected sprite colour and raw sync values are carried forward.
- Stage 2 (registered outputs), priority order:
  - not vis -> RGB 0;
  - any hit -> colour of the lowest-index hit sprite;
  - pic_in -> red=color_data_in[15:12], green=[10:7], blue=[4:1];
  - otherwise BG_COLOR.
- Latency: counter position to RGB is exactly 2 cycles. hsync/vsync are delayed by the same 2 cycles.
  - hsync=0 for h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC).
  - vsync=0 for v in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC).
- Collision: in any stage-0 cycle where two or more hit bits are set, every set bit is ORed into the accumulator. Sprites that only touch edges do not collide. A sprite with show=0 never collides.
- Sprite partially off-screen (x_i+OBJ_W > H_VIS): only the visible part is drawn; there is no wrap.
- Reset mid-line: all state clears immediately, and timing restarts at (0,0) when rst releases.

Test Plan:
- Timing: release reset and run 2 frames -> hsync period 800 clocks with a 96-clock low pulse starting at stage-0 h=656; vsync low for 2 lines starting at line 490; frame_tick period 420000 clocks.
- Picture: pic_x_begin=100, pic_y_begin=50, RAM model returns 16'hF81F -> at stage-0 (100,50), ram_addr=0 and ram_en=1; 2 cycles later RGB=F,0,F. At (99,50), RGB=FCD. At (101,51), ram_addr=641.
- Priority: obj0 at (200,200) colour 0F0, obj1 at (220,220) colour 00F, both shown -> pixel (225,225) is 0F0; (250,250) is 00F; (199,200) is picture or background.
- Collision: overlapping obj0/obj1 with obj2 separate -> collide=3'b011 after the first frame end following the latch. Move the sprites apart -> collide returns to 0 one frame later. Edge-adjacent sprites (x1=x0+40) -> collide=0.
- Tear-free: change obj_x[0] from 10 to 300 at line 100 -> the current frame still draws at x=10; the next frame draws at x=300.
- Reset mid-frame: assert rst at line 300 -> RGB=0, hsync=1, vsync=1, collide=0 asynchronously. After release, the first hsync low starts at h=656+2 cycles and no sprite is drawn in the first frame.

Source files
------------

// File: rtl/vga_sprite_display_if.sv
// Picture RAM read port: the display stage issues address/enable, the RAM returns RGB565
// data one cycle after a read enable.
interface vga_sprite_display_if #(
    parameter int unsigned ADDR_W = 19
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_en;
    logic [15:0]       color_data_in;

    modport master (output ram_addr, output ram_en, input color_data_in);
    modport slave  (input ram_addr, input ram_en, output color_data_in);
endinterface

// File: rtl/vga_sprite_display.sv
// VGA display stage: self-timed raster, background picture from RAM, N_OBJ solid sprites
// with fixed priority (index 0 on top), per-frame shadowed positions and collision flags.
module vga_sprite_display #(
    parameter int unsigned N_OBJ    = 4,
    parameter int unsigned OBJ_W    = 40,
    parameter int unsigned OBJ_H    = 40,
    parameter int unsigned PIC_W    = 640,
    parameter int unsigned PIC_H    = 480,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned H_VIS    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_VIS    = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic [11:0] BG_COLOR = 12'hFCD
) (
    input  logic                  clk_vga,
    input  logic                  rst,
    input  logic [10:0]           pic_x_begin,
    input  logic [10:0]           pic_y_begin,
    input  logic [11*N_OBJ-1:0]   obj_x,
    input  logic [11*N_OBJ-1:0]   obj_y,
    input  logic [N_OBJ-1:0]      obj_show,
    input  logic [12*N_OBJ-1:0]   obj_color,
    vga_sprite_display_if.master  ram,
    output logic                  hsync,
    output logic                  vsync,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue,
    output logic                  frame_tick,
    output logic [N_OBJ-1:0]      collide
);
    localparam int unsigned HTotal = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] HLast  = 11'(HTotal - 1);
    localparam logic [10:0] VLast  = 11'(VTotal - 1);
    localparam logic [11:0] HVis   = 12'(H_VIS);
    localparam logic [11:0] VVis   = 12'(V_VIS);
    localparam logic [11:0] HsBeg  = 12'(H_VIS + H_FP);
    localparam logic [11:0] HsEnd  = 12'(H_VIS + H_FP + H_SYNC);
    localparam logic [11:0] VsBeg  = 12'(V_VIS + V_FP);
    localparam logic [11:0] VsEnd  = 12'(V_VIS + V_FP + V_SYNC);
    localparam logic [11:0] PicW   = 12'(PIC_W);
    localparam logic [11:0] PicH   = 12'(PIC_H);
    localparam logic [11:0] ObjW   = 12'(OBJ_W);
    localparam logic [11:0] ObjH   = 12'(OBJ_H);

    logic [10:0]          h_q, v_q;
    logic [10:0]          sh_px_q, sh_py_q;
    logic [11*N_OBJ-1:0]  sh_x_q, sh_y_q;
    logic [N_OBJ-1:0]     sh_show_q;
    logic [12*N_OBJ-1:0]  sh_color_q;
    logic [N_OBJ-1:0]     acc_q;

    logic                 frame_end, vis, pic_in, multi_hit, hs_raw, vs_raw;
    logic [N_OBJ-1:0]     hit;
    logic [11:0]          sel_color;
    logic [23:0]          addr_full;

    logic                 s1_vis, s1_pic, s1_hs, s1_vs;
    logic [N_OBJ-1:0]     s1_hit;
    logic [11:0]          s1_color;
    logic                 s2_vis, s2_pic, s2_any;
    logic [11:0]          s2_color;

    assign frame_end = (h_q == HLast) && (v_q == VLast);

    // Raster counters
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == HLast) begin
            h_q <= '0;
            v_q <= (v_q == VLast) ? 11'd0 : v_q + 11'd1;
        end else begin
            h_q <= h_q + 11'd1;
        end
    end

    // Shadow copies of positions, loaded only at frame end so a frame never tears
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            sh_px_q    <= '0;
            sh_py_q    <= '0;
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_show_q  <= '0;
            sh_color_q <= '0;
        end else if (frame_end) begin
            sh_px_q    <= pic_x_begin;
            sh_py_q    <= pic_y_begin;
            sh_x_q     <= obj_x;
            sh_y_q     <= obj_y;
            sh_show_q  <= obj_show;
            sh_color_q <= obj_color;
        end
    end

    // Stage 0: window/sprite decode from the counter position, all compares at 12 bits
    always_comb begin
        logic [11:0] h12, v12, px12, py12, ox, oy, dv, dh;
        h12       = {1'b0, h_q};
        v12       = {1'b0, v_q};
        px12      = {1'b0, sh_px_q};
        py12      = {1'b0, sh_py_q};
        ox        = '0;
        oy        = '0;
        hit       = '0;
        sel_color = '0;
        vis       = (h12 < HVis) && (v12 < VVis);
        pic_in    = vis && (h12 >= px12) && (h12 < px12 + PicW)
                        && (v12 >= py12) && (v12 < py12 + PicH);
        for (int i = 0; i < int'(N_OBJ); i++) begin
            ox     = {1'b0, sh_x_q[11*i +: 11]};
            oy     = {1'b0, sh_y_q[11*i +: 11]};
            hit[i] = sh_show_q[i] && vis && (h12 >= ox) && (h12 < ox + ObjW)
                                         && (v12 >= oy) && (v12 < oy + ObjH);
        end
        // Walk from lowest priority up so the lowest-index hit wins
        for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
            if (hit[i]) sel_color = sh_color_q[12*i +: 12];
        end
        multi_hit = (hit & (hit - N_OBJ'(1))) != '0;
        dv        = v12 - py12;
        dh        = h12 - px12;
        addr_full = {12'b0, dv} * {12'b0, PicW} + {12'b0, dh};
        hs_raw    = !((h12 >= HsBeg) && (h12 < HsEnd));
        vs_raw    = !((v12 >= VsBeg) && (v12 < VsEnd));
    end

    // Collision accumulator, published and cleared at frame end
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            collide    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (frame_end) begin
                collide <= acc_q;
                acc_q   <= '0;
            end else if (multi_hit) begin
                acc_q   <= acc_q | hit;
            end
        end
    end

    // Stage 1: RAM request plus decode results carried alongside
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            s1_vis       <= 1'b0;
            s1_pic       <= 1'b0;
            s1_hit       <= '0;
            s1_color     <= '0;
            s1_hs        <= 1'b1;
            s1_vs        <= 1'b1;
            ram.ram_en   <= 1'b0;
            ram.ram_addr <= '0;
        end else begin
            s1_vis     <= vis;
            s1_pic     <= pic_in;
            s1_hit     <= hit;
            s1_color   <= sel_color;
            s1_hs      <= hs_raw;
            s1_vs      <= vs_raw;
            ram.ram_en <= pic_in;
            if (pic_in) ram.ram_addr <= addr_full[ADDR_W-1:0];
        end
    end

    // Stage 2: registered pixel decision and syncs, aligned with the RAM read data
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            s2_vis   <= 1'b0;
            s2_pic   <= 1'b0;
            s2_any   <= 1'b0;
            s2_color <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
        end else begin
            s2_vis   <= s1_vis;
            s2_pic   <= s1_pic;
            s2_any   <= |s1_hit;
            s2_color <= s1_color;
            hsync    <= s1_hs;
            vsync    <= s1_vs;
        end
    end

    // Final colour select; RAM data arrives in this cycle, so it is muxed in directly
    always_comb begin
        {red, green, blue} = 12'h000;
        if (!s2_vis)     {red, green, blue} = 12'h000;
        else if (s2_any) {red, green, blue} = s2_color;
        else if (s2_pic) {red, green, blue} = {ram.color_data_in[15:12],
                                               ram.color_data_in[10:7],
                                               ram.color_data_in[4:1]};
        else             {red, green, blue} = BG_COLOR;
    end

    logic unused_bits;
    assign unused_bits = ^{ram.color_data_in[11], ram.color_data_in[6:5],
                           ram.color_data_in[0], addr_full};
endmodule

// File: tb/tb_vga_sprite_display.sv
// Directed bench for vga_sprite_display using a reduced raster so several frames fit.
module tb_vga_sprite_display;
    localparam int HT    = 208;  // 160 + 8 + 24 + 16
    localparam int VT    = 38;   // 30 + 2 + 2 + 4
    localparam int FRAME = HT * VT;

    logic        clk, rst;
    logic [10:0] pic_x_begin, pic_y_begin;
    logic [43:0] obj_x, obj_y;
    logic [3:0]  obj_show;
    logic [47:0] obj_color;
    logic        hsync, vsync, frame_tick;
    logic [3:0]  red, green, blue, collide;
    logic [11:0] rgb;
    int          cyc;
    int          checks, errors;

    vga_sprite_display_if #(.ADDR_W(19)) ram_bus ();

    vga_sprite_display #(
        .N_OBJ(4), .OBJ_W(8), .OBJ_H(8), .PIC_W(64), .PIC_H(16), .ADDR_W(19),
        .H_VIS(160), .H_FP(8), .H_SYNC(24), .H_BP(16),
        .V_VIS(30), .V_FP(2), .V_SYNC(2), .V_BP(4), .BG_COLOR(12'hFCD)
    ) dut (
        .clk_vga(clk), .rst(rst),
        .pic_x_begin(pic_x_begin), .pic_y_begin(pic_y_begin),
        .obj_x(obj_x), .obj_y(obj_y), .obj_show(obj_show), .obj_color(obj_color),
        .ram(ram_bus.master),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .frame_tick(frame_tick), .collide(collide)
    );

    assign rgb = {red, green, blue};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model: data valid the cycle after a read enable
    always @(posedge clk) ram_bus.color_data_in <= ram_bus.ram_en ? 16'hF81F : 16'h0000;

    // Cycles since reset release == stage-0 position index
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    typedef struct {
        int          frm;
        int          h;
        int          v;
        logic        is_ram;
        logic [11:0] rgb;
        logic        en;
        logic [18:0] addr;
    } vec_t;

    vec_t vec [64];
    int   nvec;

    task automatic add_rgb(input int f, input int h, input int v, input logic [11:0] c);
        vec[nvec] = '{f, h, v, 1'b0, c, 1'b0, 19'd0};
        nvec++;
    endtask

    task automatic add_ram(input int f, input int h, input int v, input logic en,
                           input logic [18:0] a);
        vec[nvec] = '{f, h, v, 1'b1, 12'h000, en, a};
        nvec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 100000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != target) begin
            checks++;
            errors++;
            $display("FAIL goto: at cyc %0d expected %0d", cyc, target);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            int base;
            base = vec[i].frm * FRAME + vec[i].v * HT + vec[i].h;
            if (vec[i].is_ram) begin
                goto(base + 1);
                chk($sformatf("ram_en f%0d (%0d,%0d)", vec[i].frm, vec[i].h, vec[i].v),
                    32'(ram_bus.ram_en), 32'(vec[i].en));
                chk($sformatf("ram_addr f%0d (%0d,%0d)", vec[i].frm, vec[i].h, vec[i].v),
                    32'(ram_bus.ram_addr), 32'(vec[i].addr));
            end else begin
                goto(base + 2);
                chk($sformatf("rgb f%0d (%0d,%0d)", vec[i].frm, vec[i].h, vec[i].v),
                    32'(rgb), 32'(vec[i].rgb));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " rgb"}, 32'(rgb), 32'h000);
        chk({tag, " hsync"}, 32'(hsync), 32'd1);
        chk({tag, " vsync"}, 32'(vsync), 32'd1);
        chk({tag, " ram_en"}, 32'(ram_bus.ram_en), 32'd0);
        chk({tag, " ram_addr"}, 32'(ram_bus.ram_addr), 32'd0);
        chk({tag, " frame_tick"}, 32'(frame_tick), 32'd0);
        chk({tag, " collide"}, 32'(collide), 32'd0);
    endtask

    int s_f0, s_a1, s_a2, s_b2, s_r0, s_b1, s_end;

    initial begin
        checks = 0;
        errors = 0;
        nvec   = 0;
        rst    = 1'b0;
        pic_x_begin = '0; pic_y_begin = '0;
        obj_x = '0; obj_y = '0; obj_show = '0; obj_color = '0;

        // Frame 0: shadows are zero -> picture at (0,0), no sprites
        s_f0 = nvec;
        add_rgb(0, 10, 3, 12'hF0F);   add_rgb(0, 63, 15, 12'hF0F);
        add_rgb(0, 64, 15, 12'hFCD);  add_rgb(0, 105, 15, 12'hFCD);
        add_rgb(0, 63, 16, 12'hFCD);  add_rgb(0, 159, 29, 12'hFCD);
        add_rgb(0, 160, 29, 12'h000); add_rgb(0, 0, 30, 12'h000);
        // Frame 1: config A, before the mid-frame input change
        s_a1 = nvec;
        add_rgb(1, 19, 5, 12'hFCD);   add_ram(1, 20, 5, 1'b1, 19'd0);
        add_rgb(1, 20, 5, 12'hF0F);   add_rgb(1, 83, 5, 12'hF0F);
        add_ram(1, 84, 5, 1'b0, 19'd63);
        add_rgb(1, 84, 5, 12'hFCD);   add_ram(1, 21, 6, 1'b1, 19'd65);
        add_rgb(1, 99, 10, 12'hFCD);  add_rgb(1, 100, 10, 12'h0F0);
        // Frame 1 after the change: still config A
        s_a2 = nvec;
        add_rgb(1, 102, 12, 12'h0F0); add_rgb(1, 108, 12, 12'hFCD);
        add_rgb(1, 105, 15, 12'h0F0); add_rgb(1, 107, 17, 12'h0F0);
        add_rgb(1, 110, 17, 12'h00F); add_rgb(1, 100, 18, 12'hFCD);
        add_rgb(1, 20, 20, 12'hF0F);  add_rgb(1, 20, 21, 12'hFCD);
        add_rgb(1, 111, 21, 12'h00F); add_rgb(1, 112, 21, 12'hFCD);
        add_rgb(1, 145, 25, 12'hF00);
        // Frame 2: config B, up to the reset line
        s_b2 = nvec;
        add_rgb(2, 29, 10, 12'hF0F);  add_rgb(2, 30, 10, 12'h0F0);
        add_rgb(2, 37, 12, 12'h0F0);  add_rgb(2, 38, 12, 12'h00F);
        add_rgb(2, 105, 15, 12'hFCD); add_rgb(2, 45, 17, 12'h00F);
        add_rgb(2, 46, 17, 12'hF0F);
        // First frame after mid-frame reset: shadows zero again
        s_r0 = nvec;
        add_rgb(0, 33, 12, 12'hF0F);  add_rgb(0, 38, 12, 12'hF0F);
        add_rgb(0, 0, 23, 12'hFCD);
        // Second frame after reset: config B incl. partially off-screen sprite
        s_b1 = nvec;
        add_rgb(1, 29, 10, 12'hF0F);  add_rgb(1, 30, 10, 12'h0F0);
        add_rgb(1, 37, 12, 12'h0F0);  add_rgb(1, 38, 12, 12'h00F);
        add_rgb(1, 159, 22, 12'hF00); add_rgb(1, 160, 22, 12'h000);
        add_rgb(1, 0, 23, 12'hFCD);   add_rgb(1, 156, 27, 12'hF00);
        add_rgb(1, 156, 28, 12'hFCD);
        s_end = nvec;

        #12;
        check_reset_outputs("reset");

        // Config A: obj0/obj1 overlap, obj2 apart, obj3 hidden on top of obj0
        pic_x_begin = 11'd20;
        pic_y_begin = 11'd5;
        obj_x     = {11'd102, 11'd140, 11'd104, 11'd100};
        obj_y     = {11'd12, 11'd20, 11'd14, 11'd10};
        obj_show  = 4'b0111;
        obj_color = {12'hFFF, 12'hF00, 12'h00F, 12'h0F0};
        repeat (3) @(negedge clk);
        rst = 1'b1;

        goto(167 + 2); chk("hsync h167", 32'(hsync), 32'd1);
        goto(168 + 2); chk("hsync h168", 32'(hsync), 32'd0);
        goto(191 + 2); chk("hsync h191", 32'(hsync), 32'd0);
        goto(192 + 2); chk("hsync h192", 32'(hsync), 32'd1);
        run_vecs(s_f0, s_a1);
        goto(31 * HT + 2);      chk("vsync v31", 32'(vsync), 32'd1);
        goto(32 * HT + 2);      chk("vsync v32", 32'(vsync), 32'd0);
        goto(33 * HT + 209);    chk("vsync v33 end", 32'(vsync), 32'd0);
        goto(34 * HT + 2);      chk("vsync v34", 32'(vsync), 32'd1);
        goto(FRAME - 1);        chk("frame_tick pre", 32'(frame_tick), 32'd0);
        goto(FRAME);            chk("frame_tick 0", 32'(frame_tick), 32'd1);
        goto(FRAME + 1);        chk("frame_tick post", 32'(frame_tick), 32'd0);
        chk("collide frame0", 32'(collide), 32'd0);

        run_vecs(s_a1, s_a2);
        // Config B mid-frame: sprites move apart, obj1 edge-adjacent to obj0
        goto(FRAME + 12 * HT);
        obj_x = {11'd0, 11'd156, 11'd38, 11'd30};
        obj_y = {11'd0, 11'd20, 11'd10, 11'd10};
        run_vecs(s_a2, s_b2);

        goto(2 * FRAME - 1);    chk("collide before end1", 32'(collide), 32'd0);
        goto(2 * FRAME);        chk("collide frame1", 32'(collide), 32'b0011);
        chk("frame_tick 1", 32'(frame_tick), 32'd1);
        goto(2 * FRAME + HT);   chk("collide held", 32'(collide), 32'b0011);
        run_vecs(s_b2, s_r0);

        // Asynchronous reset while hsync is low
        goto(2 * FRAME + 18 * HT + 185);
        chk("hsync low pre-reset", 32'(hsync), 32'd0);
        #2 rst = 1'b0;
        #1 check_reset_outputs("mid reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        goto(167 + 2); chk("hsync post-rst h167", 32'(hsync), 32'd1);
        goto(168 + 2); chk("hsync post-rst h168", 32'(hsync), 32'd0);
        run_vecs(s_r0, s_b1);
        goto(FRAME + 1);        chk("collide after rst f0", 32'(collide), 32'd0);
        run_vecs(s_b1, s_end);
        goto(2 * FRAME);        chk("collide apart/adjacent", 32'(collide), 32'd0);
        chk("frame_tick after rst", 32'(frame_tick), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
